// File: rtl/cpu_trace_monitor.sv
// Run monitor for the multicycle CPU: cycle/instruction counters, stall/timeout
// run control and a circular trace buffer of register write-backs with a registered read port.
module cpu_trace_monitor #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned MAX_CYCLES  = 75,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       clear,
  input  logic                       PCWre,
  input  logic                       RegWre,
  input  logic [DATA_W-1:0]          _Pc0,
  input  logic [4:0]                 _thirdRg,
  input  logic [DATA_W-1:0]          _WBdata,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]          rd_wb,
  output logic [4:0]                 rd_reg,
  output logic                       rd_valid,
  output logic [1:0]                 state,
  output logic [15:0]                cycle_count,
  output logic [15:0]                instr_count,
  output logic [$clog2(DEPTH):0]     entries,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StHalted  = 2'b01,
    StTimeout = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     cycle_q, cycle_d;
  logic [15:0]     instr_q, instr_d;
  logic [15:0]     stall_q, stall_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     entries_q, entries_d;
  logic            overflow_q, overflow_d;
  logic [DATA_W-1:0] rd_pc_q, rd_pc_d;
  logic [DATA_W-1:0] rd_wb_q, rd_wb_d;
  logic [4:0]      rd_reg_q, rd_reg_d;
  logic            rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] wb_mem [DEPTH];
  logic [4:0]        reg_mem [DEPTH];

  logic          capture;
  logic [AW-1:0] rd_phys;
  logic          buf_full;

  assign buf_full = (entries_q == (AW+1)'(DEPTH));
  assign capture  = !clear && (state_q == StRun) && RegWre;
  // Once wrapped, the oldest entry sits at the write pointer.
  assign rd_phys  = (overflow_q ? wr_ptr_q : '0) + rd_addr;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    stall_d    = stall_q;
    wr_ptr_d   = wr_ptr_q;
    entries_d  = entries_q;
    overflow_d = overflow_q;
    rd_pc_d    = rd_pc_q;
    rd_wb_d    = rd_wb_q;
    rd_reg_d   = rd_reg_q;
    rd_valid_d = rd_en;

    if (rd_en) begin
      if ({1'b0, rd_addr} >= entries_q) begin
        rd_pc_d  = '0;
        rd_wb_d  = '0;
        rd_reg_d = '0;
      end else begin
        rd_pc_d  = pc_mem[rd_phys];
        rd_wb_d  = wb_mem[rd_phys];
        rd_reg_d = reg_mem[rd_phys];
      end
    end

    if (clear) begin
      state_d    = StRun;
      cycle_d    = '0;
      instr_d    = '0;
      stall_d    = '0;
      wr_ptr_d   = '0;
      entries_d  = '0;
      overflow_d = 1'b0;
      rd_pc_d    = '0;
      rd_wb_d    = '0;
      rd_reg_d   = '0;
      rd_valid_d = 1'b0;
    end else if (state_q == StRun) begin
      cycle_d = cycle_q + 16'd1;
      if (PCWre) begin
        instr_d = instr_q + 16'd1;
        stall_d = '0;
      end else begin
        stall_d = stall_q + 16'd1;
      end
      if (RegWre) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (buf_full) overflow_d = 1'b1;
        else          entries_d  = entries_q + 1'b1;
      end
      // Halt takes precedence when both limits land on the same edge.
      if (!PCWre && stall_q == 16'(STALL_LIMIT - 1)) begin
        state_d = StHalted;
      end else if (cycle_q == 16'(MAX_CYCLES - 1)) begin
        state_d = StTimeout;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StRun;
      cycle_q    <= '0;
      instr_q    <= '0;
      stall_q    <= '0;
      wr_ptr_q   <= '0;
      entries_q  <= '0;
      overflow_q <= 1'b0;
      rd_pc_q    <= '0;
      rd_wb_q    <= '0;
      rd_reg_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      stall_q    <= stall_d;
      wr_ptr_q   <= wr_ptr_d;
      entries_q  <= entries_d;
      overflow_q <= overflow_d;
      rd_pc_q    <= rd_pc_d;
      rd_wb_q    <= rd_wb_d;
      rd_reg_q   <= rd_reg_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Trace RAM is not reset; validity is tracked by entries_q.
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_mem[wr_ptr_q]  <= _Pc0;
      wb_mem[wr_ptr_q]  <= _WBdata;
      reg_mem[wr_ptr_q] <= _thirdRg;
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
  assign entries     = entries_q;
  assign overflow    = overflow_q;
  assign rd_pc       = rd_pc_q;
  assign rd_wb       = rd_wb_q;
  assign rd_reg      = rd_reg_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: timeout, halt, trace wrap/readback, clear and async reset.
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        Reset;
  logic        clear;
  logic        PCWre;
  logic        RegWre;
  logic [31:0] _Pc0;
  logic [4:0]  _thirdRg;
  logic [31:0] _WBdata;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic [31:0] rd_pc, rd_wb;
  logic [4:0]  rd_reg;
  logic        rd_valid;
  logic [1:0]  state;
  logic [15:0] cycle_count, instr_count;
  logic [4:0]  entries;
  logic        overflow;

  logic [31:0] rd_pc2, rd_wb2;
  logic [4:0]  rd_reg2;
  logic        rd_valid2;
  logic [1:0]  state2;
  logic [15:0] cycle_count2, instr_count2;
  logic [4:0]  entries2;
  logic        overflow2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_trace_monitor u_dut (
    .clk(clk), .Reset(Reset), .clear(clear), .PCWre(PCWre), .RegWre(RegWre),
    ._Pc0(_Pc0), ._thirdRg(_thirdRg), ._WBdata(_WBdata), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_pc(rd_pc), .rd_wb(rd_wb), .rd_reg(rd_reg), .rd_valid(rd_valid), .state(state),
    .cycle_count(cycle_count), .instr_count(instr_count), .entries(entries),
    .overflow(overflow)
  );

  // Second instance with equal stall and cycle limits for the same-edge priority case.
  cpu_trace_monitor #(.MAX_CYCLES(8), .STALL_LIMIT(8)) u_dut2 (
    .clk(clk), .Reset(Reset), .clear(clear), .PCWre(PCWre), .RegWre(RegWre),
    ._Pc0(_Pc0), ._thirdRg(_thirdRg), ._WBdata(_WBdata), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_pc(rd_pc2), .rd_wb(rd_wb2), .rd_reg(rd_reg2), .rd_valid(rd_valid2), .state(state2),
    .cycle_count(cycle_count2), .instr_count(instr_count2), .entries(entries2),
    .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0; clear = 1'b0; PCWre = 1'b0; RegWre = 1'b0;
    _Pc0 = '0; _thirdRg = '0; _WBdata = '0; rd_en = 1'b0; rd_addr = '0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cycle", 32'(cycle_count), 32'd0);
    chk("rst_entries", 32'(entries), 32'd0);
    tick(); tick();

    // Timeout with PCWre held high
    Reset = 1'b1; PCWre = 1'b1;
    repeat (74) tick();
    chk("pre_to_state", 32'(state), 32'd0);
    chk("pre_to_cycle", 32'(cycle_count), 32'd74);
    tick();
    chk("to_state", 32'(state), 32'd2);
    chk("to_cycle", 32'(cycle_count), 32'd75);
    chk("to_instr", 32'(instr_count), 32'd75);
    chk("to_entries", 32'(entries), 32'd0);
    repeat (10) tick();
    chk("frozen_state", 32'(state), 32'd2);
    chk("frozen_cycle", 32'(cycle_count), 32'd75);
    chk("frozen_instr", 32'(instr_count), 32'd75);

    // Clear from TIMEOUT
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_state", 32'(state), 32'd0);
    chk("clr_cycle", 32'(cycle_count), 32'd0);
    chk("clr_instr", 32'(instr_count), 32'd0);
    chk("clr_entries", 32'(entries), 32'd0);

    // Stall to HALTED; dut2 hits stall and cycle limit together
    PCWre = 1'b0;
    repeat (7) tick();
    chk("pre_halt_state", 32'(state), 32'd0);
    tick();
    chk("halt_state", 32'(state), 32'd1);
    chk("halt_cycle", 32'(cycle_count), 32'd8);
    chk("halt_instr", 32'(instr_count), 32'd0);
    chk("both_state", 32'(state2), 32'd1);
    chk("both_cycle", 32'(cycle_count2), 32'd8);

    // Retire at edge 5 restarts the stall count
    clear = 1'b1; tick(); clear = 1'b0;
    PCWre = 1'b0;
    repeat (4) tick();
    PCWre = 1'b1; tick();
    PCWre = 1'b0;
    repeat (7) tick();
    chk("toggle_pre_state", 32'(state), 32'd0);
    tick();
    chk("toggle_state", 32'(state), 32'd1);
    chk("toggle_cycle", 32'(cycle_count), 32'd13);
    chk("toggle_instr", 32'(instr_count), 32'd1);

    // 20 captures into a 16-entry buffer
    clear = 1'b1; tick(); clear = 1'b0;
    PCWre = 1'b1; RegWre = 1'b1;
    for (int i = 0; i < 20; i++) begin
      _Pc0 = 32'h100 + 32'(4 * i);
      _thirdRg = 5'(i);
      _WBdata = 32'(i);
      tick();
    end
    RegWre = 1'b0;
    chk("ovf_entries", 32'(entries), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    rd_en = 1'b1; rd_addr = 4'd0; tick();
    chk("rd0_valid", 32'(rd_valid), 32'd1);
    chk("rd0_wb", rd_wb, 32'd4);
    chk("rd0_reg", 32'(rd_reg), 32'd4);
    chk("rd0_pc", rd_pc, 32'h110);
    rd_addr = 4'd15; tick();
    chk("rd15_wb", rd_wb, 32'd19);
    chk("rd15_pc", rd_pc, 32'h14c);
    rd_en = 1'b0; tick();
    chk("rd_idle_valid", 32'(rd_valid), 32'd0);
    chk("rd_idle_hold", rd_wb, 32'd19);

    // Two entries, read beyond and within the valid range
    clear = 1'b1; tick(); clear = 1'b0;
    RegWre = 1'b1; _Pc0 = 32'h200; _thirdRg = 5'd7; _WBdata = 32'ha0; tick();
    _Pc0 = 32'h204; _thirdRg = 5'd9; _WBdata = 32'ha1; tick();
    RegWre = 1'b0;
    chk("two_entries", 32'(entries), 32'd2);
    chk("two_ovf", 32'(overflow), 32'd0);
    rd_en = 1'b1; rd_addr = 4'd3; tick();
    chk("oob_valid", 32'(rd_valid), 32'd1);
    chk("oob_wb", rd_wb, 32'd0);
    chk("oob_pc", rd_pc, 32'd0);
    chk("oob_reg", 32'(rd_reg), 32'd0);
    rd_addr = 4'd1; tick();
    chk("in_wb", rd_wb, 32'ha1);
    chk("in_reg", 32'(rd_reg), 32'd9);
    rd_en = 1'b0;

    // Asynchronous reset between edges
    tick();
    #2 Reset = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_cycle", 32'(cycle_count), 32'd0);
    chk("arst_instr", 32'(instr_count), 32'd0);
    chk("arst_entries", 32'(entries), 32'd0);
    chk("arst_rd_wb", rd_wb, 32'd0);
    chk("arst_rd_pc", rd_pc, 32'd0);
    Reset = 1'b1;
    tick();
    chk("restart_cycle", 32'(cycle_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
